// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, I-cache read port,
// IF/ID pipeline register and fetch performance counters.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_id,
   input  logic        PCSrc,
   input  logic        IF_Flush,
   input  logic        Jump,
   input  logic        JumpR,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   input  logic        ICACHE_stall,
   input  logic [31:0] ICACHE_rdata,
   output logic        ICACHE_ren,
   output logic [29:0] ICACHE_addr,
   output logic [31:0] pc,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [31:0] cnt_fetch,
   output logic [31:0] cnt_flush,
   output logic [31:0] cnt_stall
);

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        redir;
   logic        advance;
   logic        unused_low_bits;

   // Targets are word aligned; the byte-offset bits of the inputs are dropped.
   assign unused_low_bits = ^{jr_target[1:0], branch_target[1:0]};

   assign pc_plus4    = pc + 32'd4;
   assign redir       = (PCSrc | Jump | JumpR) & ~stall_id;
   assign advance     = ~ICACHE_stall & ~stall_id;
   assign ICACHE_addr = pc[31:2];
   // The read port is idle only while reset is held.
   assign ICACHE_ren  = rst_n;

   always_comb begin
      // NOTE: default assigned first so every path drives next_pc and no latch is inferred.
      next_pc = pc_plus4;
      if (redir) begin
         if (JumpR)
            next_pc = {jr_target[31:2], 2'b00};
         else if (Jump)
            next_pc = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};
         else if (PCSrc)
            next_pc = {branch_target[31:2], 2'b00};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         ifid_inst  <= '0;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
         cnt_fetch  <= '0;
         cnt_flush  <= '0;
         cnt_stall  <= '0;
      end else if (!advance) begin
         // Either stall freezes the stage; redirects and flushes are re-presented later.
         cnt_stall <= cnt_stall + 32'd1;
      end else begin
         pc       <= next_pc;
         ifid_pc4 <= pc_plus4;
         if (IF_Flush) begin
            ifid_inst  <= '0;
            ifid_valid <= 1'b0;
            cnt_flush  <= cnt_flush + 32'd1;
         end else begin
            ifid_inst  <= ICACHE_rdata;
            ifid_valid <= 1'b1;
            cnt_fetch  <= cnt_fetch + 32'd1;
         end
      end
   end

endmodule
